kernel_invoke_arbiter: RTL

//  Shares one untagged dataflow kernel instance (single arg channel, single result channel) among
//  N_REQ requesters. Grants round-robin, allows exactly one invocation in flight, and routes the

---
 rtl/kernel_arb_pkg.sv | 27 ++
 rtl/kernel_invoke_arbiter_rr_pick.sv | 46 ++++
 rtl/kernel_invoke_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/kernel_arb_pkg.sv
// -----------------------------------------------------------------------------
// kernel_arb_pkg
//   Shared types and constants for the kernel invocation arbiter.
//   - arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   - *_DEF       : default parameter values used by the arbiter and picker
//   - idx_w()     : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package kernel_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam int N_REQ_DEF = 4;
   localparam int ARG_W_DEF = 10;
   localparam int RES_W_DEF = 10;
   localparam int LAT_W_DEF = 16;
   localparam int CNT_W_DEF = 16;

   // Index width for n requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kernel_invoke_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the index of the first set bit
//   of req found by searching upward from rr_ptr, wrapping modulo N_REQ.
//   Ports:
//     req     in   N_REQ   request vector
//     rr_ptr  in   IDX_W   search start position
//     grant   out  IDX_W   selected index (0 when nothing requests)
//     any     out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_pick
   import kernel_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = idx_w(N_REQ)
)
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] grant,
   output logic             any
);

   // Candidate gi is the requester gi positions past rr_ptr.
   logic [IDX_W-1:0] cand_idx [N_REQ];
   logic [N_REQ-1:0] cand_hit;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
         assign cand_idx[gi] = IDX_W'((int'(rr_ptr) + gi) % N_REQ);
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      grant = '0;
      any   = |req;
      // Walk from the farthest candidate back toward rr_ptr so the nearest wins.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         if (cand_hit[off]) begin
            grant = cand_idx[off];
         end
      end
   end

endmodule

// File: rtl/kernel_invoke_arbiter.sv
// -----------------------------------------------------------------------------
// kernel_invoke_arbiter
//   Shares one untagged dataflow kernel among N_REQ requesters. Grants are
//   round-robin, exactly one invocation is in flight, and the kernel result is
//   routed back to the requester that issued the argument.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     req_arg         packed requester args, slice i = requester i
//     req_valid       requester i has an arg
//     req_ready       arg i accepted (one-hot or zero)
//     res_data        kernel result, broadcast to all requesters
//     res_valid       result valid for requester i (one-hot or zero)
//     res_ready       requester i accepts the result
//     k_arg/_valid/_ready   kernel argument channel
//     k_res/_valid/_ready   kernel result channel
//     busy            arbiter not idle
//     owner           current or last grantee
//     last_latency    cycles from arg handshake to result handshake (saturating)
//     invoke_count    completed invocations (wrapping)
// -----------------------------------------------------------------------------
module kernel_invoke_arbiter
   import kernel_arb_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   parameter  int ARG_W = ARG_W_DEF,
   parameter  int RES_W = RES_W_DEF,
   parameter  int LAT_W = LAT_W_DEF,
   parameter  int CNT_W = CNT_W_DEF,
   localparam int IDX_W = idx_w(N_REQ)
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ*ARG_W-1:0] req_arg,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   output logic [RES_W-1:0]       res_data,
   output logic [N_REQ-1:0]       res_valid,
   input  logic [N_REQ-1:0]       res_ready,
   output logic [ARG_W-1:0]       k_arg,
   output logic                   k_arg_valid,
   input  logic                   k_arg_ready,
   input  logic [RES_W-1:0]       k_res,
   input  logic                   k_res_valid,
   output logic                   k_res_ready,
   output logic                   busy,
   output logic [IDX_W-1:0]       owner,
   output logic [LAT_W-1:0]       last_latency,
   output logic [CNT_W-1:0]       invoke_count
);

   arb_state_t       state_reg, state_next;
   logic [IDX_W-1:0] owner_reg, owner_next;
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [LAT_W-1:0] lat_reg, lat_next;
   logic [LAT_W-1:0] last_latency_reg, last_latency_next;
   logic [CNT_W-1:0] invoke_count_reg, invoke_count_next;

   logic [ARG_W-1:0] arg_slice [N_REQ];
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             owner_valid;
   logic [LAT_W-1:0] lat_inc;
   logic [IDX_W-1:0] owner_plus1;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_arg
         assign arg_slice[gi] = req_arg[gi*ARG_W +: ARG_W];
      end
   endgenerate

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_reg),
      .grant  (pick_idx),
      .any    (pick_any)
   );

   assign owner_valid = req_valid[owner_reg];
   // Saturating increment so very long stalls pin at all-ones instead of wrapping.
   assign lat_inc     = (lat_reg == {LAT_W{1'b1}}) ? lat_reg : lat_reg + LAT_W'(1);
   assign owner_plus1 = (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         owner_reg        <= '0;
         rr_ptr_reg       <= '0;
         lat_reg          <= '0;
         last_latency_reg <= '0;
         invoke_count_reg <= '0;
      end else begin
         state_reg        <= state_next;
         owner_reg        <= owner_next;
         rr_ptr_reg       <= rr_ptr_next;
         lat_reg          <= lat_next;
         last_latency_reg <= last_latency_next;
         invoke_count_reg <= invoke_count_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      owner_next        = owner_reg;
      rr_ptr_next       = rr_ptr_reg;
      lat_next          = lat_reg;
      last_latency_next = last_latency_reg;
      invoke_count_next = invoke_count_reg;
      req_ready         = '0;
      res_valid         = '0;
      res_data          = '0;
      k_arg             = '0;
      k_arg_valid       = 1'b0;
      k_res_ready       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               owner_next = pick_idx;
               state_next = ISSUE;
            end
         end

         ISSUE: begin
            k_arg                = arg_slice[owner_reg];
            k_arg_valid          = owner_valid;
            req_ready[owner_reg] = k_arg_ready;
            if (owner_valid && k_arg_ready) begin
               lat_next   = '0;
               state_next = WAIT;
            end else if (!owner_valid) begin
               // Owner withdrew before the kernel took the arg: nothing was
               // issued, so the round-robin pointer stays where it was.
               state_next = IDLE;
            end
         end

         WAIT: begin
            res_data             = k_res;
            res_valid[owner_reg] = k_res_valid;
            k_res_ready          = res_ready[owner_reg];
            lat_next             = lat_inc;
            if (k_res_valid && res_ready[owner_reg]) begin
               // The handshake cycle itself counts, so a result taken N cycles
               // after the arg handshake reports N.
               last_latency_next = lat_inc;
               invoke_count_next = invoke_count_reg + CNT_W'(1);
               rr_ptr_next       = owner_plus1;
               state_next        = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign busy         = (state_reg != IDLE);
   assign owner        = owner_reg;
   assign last_latency = last_latency_reg;
   assign invoke_count = invoke_count_reg;

endmodule
